// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: FSM state encodings and constants shared by the fetch front end.
package pc_fetch_pkg;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'hBFC00000;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_fetch_next_sel.sv
// pc_next_sel: next-PC mux (flush > branch > sequential) with target alignment handling.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  logic [31:0] raw;
  always_comb begin
    raw = flush ? new_pc : branch ? branch_target : pc + PC_INC;
`ifdef FETCH_ALIGN_CHECK_EN
    next_pc = raw;
    misaligned = |raw[1:0];
`else
    next_pc = raw & ~32'h3;
    misaligned = 1'b0;
`endif
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC owner and instruction-bus fetch FSM feeding IF/ID.
// FETCH_ALIGN_CHECK_EN adds fetch_except_o and traps misaligned redirect targets.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_stb_o,
  output logic [31:0] ibus_addr_o,
  input  logic [31:0] ibus_rdata_i,
  input  logic        ibus_ack_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic      fetch_except_o
`endif
);
  state_t      state, nstate;
  logic [31:0] pc, tgt, buf_inst, buf_pc, sel_pc, go_pc;
  logic        tgt_bad, trap, buf_valid, sel_bad, go, go_bad, latch, capture;
  logic        unused_stall;

  pc_next_sel u_sel (
    .flush(flush), .new_pc(new_pc), .branch(branch_flag_i), .branch_target(branch_target_i),
    .pc(pc), .next_pc(sel_pc), .misaligned(sel_bad)
  );

  assign unused_stall = ^stall[5:2];
  assign ibus_stb_o   = state == S_FETCH || state == S_DRAIN;
  assign ibus_addr_o  = pc & ~32'h3;
  assign stallreq_o   = (state == S_FETCH && !ibus_ack_i) || state == S_DRAIN;
  assign capture      = state == S_FETCH && ibus_ack_i && !flush;

  // go: PC takes go_pc this cycle; latch: remember a redirect until the outstanding ack
  always_comb begin
    nstate = state;
    go = 1'b0;
    go_pc = sel_pc;
    go_bad = sel_bad;
    latch = 1'b0;
    case (state)
      S_BOOT: begin
        go = flush;
        nstate = S_FETCH;
      end
      S_FETCH: begin
        go = flush & ibus_ack_i;
        latch = (flush | branch_flag_i) & ~ibus_ack_i;
        nstate = latch ? S_DRAIN : capture ? S_HOLD : S_FETCH;
      end
      S_HOLD: go = flush | (~stall[0] & ~trap);
      S_DRAIN: begin
        go = ibus_ack_i;
        latch = flush & ~ibus_ack_i;
        go_pc = flush ? sel_pc : tgt;
        go_bad = flush ? sel_bad : tgt_bad;
      end
    endcase
    nstate = go ? (go_bad ? S_HOLD : S_FETCH) : nstate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_BOOT;
      pc <= RESET_PC;
      tgt <= RESET_PC;
      tgt_bad <= 1'b0;
      trap <= 1'b0;
      buf_inst <= '0;
      buf_pc <= RESET_PC;
      buf_valid <= 1'b0;
      pc_o <= RESET_PC;
      inst_o <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      state <= nstate;
      if (go) pc <= go_pc;
      if (latch) begin
        tgt <= sel_pc;
        tgt_bad <= sel_bad;
      end
      trap <= go ? go_bad : trap;
      if (capture) begin
        buf_inst <= ibus_rdata_i;
        buf_pc <= pc;
      end
      buf_valid <= ~flush & (capture ? stall[1] : buf_valid & stall[1]);
      if (go && go_bad) pc_o <= go_pc;
      else if (!flush && !stall[1]) pc_o <= capture ? pc : buf_pc;
      if (flush || (go && go_bad)) begin
        inst_o <= '0;
        inst_valid_o <= 1'b0;
      end else if (!stall[1]) begin
        inst_o <= capture ? ibus_rdata_i : buf_inst & {32{buf_valid}};
        inst_valid_o <= capture | buf_valid;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_except_o <= 1'b0;
    else fetch_except_o <= go & go_bad;
  end
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized fetch stream checked by an address-sequence model and output scoreboard.
module tb_pc_fetch;
  localparam logic [31:0] RST_PC = 32'hBFC00000;
  logic        clk = 0, rst = 0;
  logic [5:0]  stall = 0;
  logic        flush = 0, branch_flag_i = 0, ibus_ack_i = 0;
  logic [31:0] new_pc = 0, branch_target_i = 0, ibus_rdata_i = 0;
  logic        ibus_stb_o, inst_valid_o, stallreq_o;
  logic [31:0] ibus_addr_o, pc_o, inst_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_except_o;
`endif
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic        upd = 0;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .ibus_stb_o(ibus_stb_o), .ibus_addr_o(ibus_addr_o), .ibus_rdata_i(ibus_rdata_i),
    .ibus_ack_i(ibus_ack_i), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .stallreq_o(stallreq_o)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_except_o(fetch_except_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL sim_timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // IF/ID only advances on edges where stall[1] was low
  always @(posedge clk) upd <= ~stall[1];

  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (rst && upd && inst_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %08h inst %08h, none expected", pc_o, inst_o);
      end else begin
        e = sb.pop_front();
        check("out_pc", pc_o, e[63:32]);
        check("out_inst", inst_o, e[31:0]);
      end
    end
  end

  task automatic cyc(input logic [5:0] st = 0, input logic fl = 0, input logic [31:0] np = 0,
                     input logic br = 0, input logic [31:0] bt = 0);
    @(negedge clk);
    stall = st; flush = fl; new_pc = np; branch_flag_i = br; branch_target_i = bt;
    ibus_ack_i = 0; ibus_rdata_i = mem(ibus_addr_o);
    #1;
  endtask

  task automatic await_stb(output logic ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      ok = ibus_stb_o;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL stb_timeout: strobe never rose within 20 cycles");
    end
  endtask

  task automatic fetch(input logic [31:0] exp, input int lat, input logic [5:0] st);
    logic ok;
    logic [31:0] a;
    await_stb(ok);
    if (!ok) return;
    check("fetch_addr", ibus_addr_o, exp);
    a = ibus_addr_o;
    for (int i = 0; i < lat; i++) begin
      check("stallreq_wait", 32'(stallreq_o), 1);
      cyc();
      check("addr_stable", ibus_addr_o, a);
    end
    ibus_ack_i = 1;
    stall = st;
    #1 check("stallreq_ack", 32'(stallreq_o), 0);
    sb.push_back({exp, mem(exp)});
  endtask

  task automatic hold(input int k, input logic br, input logic [31:0] bt);
    for (int i = 0; i < k; i++) begin
      cyc(6'b000011, 0, 0, br, bt);
      check("hold_no_stb", 32'(ibus_stb_o), 0);
    end
    cyc(0, 0, 0, br, bt);
  endtask

  initial begin
    logic [31:0] cur, tgt;
    logic ok, br;
    int act;
    logic [5:0] st;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc_o", pc_o, RST_PC);
    check("rst_inst_o", inst_o, 0);
    check("rst_valid", 32'(inst_valid_o), 0);
    check("rst_stb", 32'(ibus_stb_o), 0);
    check("rst_addr", ibus_addr_o, RST_PC);
    check("rst_stallreq", 32'(stallreq_o), 0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_except", 32'(fetch_except_o), 0);
`endif
    rst = 1;
    #1 check("boot_stb", 32'(ibus_stb_o), 0);
    fetch(RST_PC, 0, 0);
    hold(0, 0, 0);
    fetch(RST_PC + 4, 3, 0);
    hold(2, 1, 32'h80001000);
    fetch(32'h80001000, 1, 6'b000011);
    hold(1, 0, 0);
    fetch(32'h80001004, 0, 0);
    cyc(0, 1, 32'hFFFFFFFC);
    fetch(32'hFFFFFFFC, 0, 0);
    hold(0, 0, 0);
    fetch(32'h00000000, 2, 0);
    hold(0, 0, 0);
    // flush while the ack is pending, then overwrite the target during drain
    await_stb(ok);
    cyc(0, 1, 32'h80000100);
    cyc(0, 1, 32'h80000180);
    check("drain_stallreq", 32'(stallreq_o), 1);
    check("drain_stb", 32'(ibus_stb_o), 1);
    check("drain_addr", ibus_addr_o, 32'h00000004);
    cyc();
    check("drain_addr_hold", ibus_addr_o, 32'h00000004);
    ibus_ack_i = 1;
    cyc();
    check("drain_discard", 32'(inst_valid_o), 0);
    fetch(32'h80000180, 0, 0);
    hold(0, 0, 0);
    // flush coinciding with ack
    await_stb(ok);
    ibus_ack_i = 1;
    flush = 1;
    new_pc = 32'h80000200;
    cyc();
    check("flush_ack_discard", 32'(inst_valid_o), 0);
    fetch(32'h80000200, 0, 0);
    cyc(0, 1, 32'h80000002);
`ifdef FETCH_ALIGN_CHECK_EN
    cyc();
    check("mis_except", 32'(fetch_except_o), 1);
    check("mis_pc_o", pc_o, 32'h80000002);
    check("mis_valid", 32'(inst_valid_o), 0);
    check("mis_stb", 32'(ibus_stb_o), 0);
    cyc();
    check("mis_except_pulse", 32'(fetch_except_o), 0);
    check("mis_stb_wait", 32'(ibus_stb_o), 0);
    cyc(0, 1, 32'h80000010);
    fetch(32'h80000010, 0, 0);
`else
    fetch(32'h80000000, 0, 0);
`endif
    // asynchronous reset in the middle of a fetch
    hold(0, 0, 0);
    await_stb(ok);
    #2 rst = 0;
    #1;
    check("async_rst_stb", 32'(ibus_stb_o), 0);
    check("async_rst_pc_o", pc_o, RST_PC);
    check("async_rst_stallreq", 32'(stallreq_o), 0);
    @(negedge clk);
    rst = 1;
    cur = RST_PC;
    for (int n = 0; n < 60; n++) begin
      act = int'($urandom_range(0, 5));
      st = (act != 0 && $urandom_range(0, 1) == 1) ? 6'b000011 : 6'b000000;
      fetch(cur, int'($urandom_range(0, 3)), st);
      tgt = $urandom & 32'hFFFFFFFC;
      if (act == 0) begin
        cyc(0, 1, tgt);
        cur = tgt;
      end else begin
        br = act == 1;
        hold(int'($urandom_range(0, 2)), br, tgt);
        cur = br ? tgt : cur + 32'd4;
      end
    end
    cyc();
    cyc();
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
